// File: rtl/unary_expander_if.sv
// Handshake bundle for unary_expander: count words in, serial unary bits
// plus a parallel thermometer view out.
interface unary_expander_if #(
  parameter int N  = 5,
  parameter int CW = 3
);
  logic          in_valid;
  logic [CW-1:0] in_count;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready;
  logic          out_bit;
  logic          out_last;
  logic [N-1:0]  out_therm;
  logic          err;

  modport master (
    output in_valid, in_count, out_ready,
    input  in_ready, out_valid, out_bit, out_last, out_therm, err
  );

  modport slave (
    input  in_valid, in_count, out_ready,
    output in_ready, out_valid, out_bit, out_last, out_therm, err
  );
endinterface

// File: rtl/unary_expander.sv
// Expands a population count into an N-bit unary frame, ones first, LSB-first.
// Optional sticky illegal-count flag is built only when UNARY_COUNT_ERR_EN is defined.
module unary_expander #(
  parameter int N  = 5,
  parameter int CW = 3
) (
  input  logic            clk,
  input  logic            rst,
  unary_expander_if.slave bus
);
  typedef enum logic {IDLE, SHIFT} state_t;

  localparam logic [CW-1:0] N_C    = CW'(N);
  localparam logic [CW-1:0] LAST_C = CW'(N - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] idx_q, idx_d;
  logic          out_valid_q, out_valid_d;
  logic          out_bit_q, out_bit_d;
  logic          out_last_q, out_last_d;
  logic [N-1:0]  out_therm_q, out_therm_d;
  logic [CW-1:0] count_sat;
  logic          in_ready, in_fire, out_fire, shift_d;

  assign count_sat = (bus.in_count > N_C) ? N_C : bus.in_count;
  // A new frame may start only when the current one is leaving on this edge.
  assign in_ready  = !rst && ((state_q == IDLE) ||
                              (out_valid_q && bus.out_ready && out_last_q));
  assign in_fire   = bus.in_valid && in_ready;
  assign out_fire  = out_valid_q && bus.out_ready;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (in_fire) begin
          state_d = SHIFT;
          count_d = count_sat;
          idx_d   = '0;
        end
      end
      SHIFT: begin
        if (out_fire) begin
          if (out_last_q) begin
            idx_d = '0;
            if (in_fire) count_d = count_sat;
            else         state_d = IDLE;
          end else begin
            idx_d = idx_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next-state view so they line up with idx.
  assign shift_d     = (state_d == SHIFT);
  assign out_valid_d = shift_d;
  assign out_bit_d   = shift_d && (idx_d < count_d);
  assign out_last_d  = shift_d && (idx_d == LAST_C);

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_therm
      assign out_therm_d[gi] = shift_d && (count_d > CW'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_bit_q   <= 1'b0;
      out_last_q  <= 1'b0;
      out_therm_q <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_bit_q   <= out_bit_d;
      out_last_q  <= out_last_d;
      out_therm_q <= out_therm_d;
    end
  end

  // Reset blanks the outputs within the reset cycle itself.
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q && !rst;
  assign bus.out_bit   = out_bit_q && !rst;
  assign bus.out_last  = out_last_q && !rst;
  assign bus.out_therm = rst ? '0 : out_therm_q;

`ifdef UNARY_COUNT_ERR_EN
  logic err_q, err_d;

  assign err_d = err_q || (in_fire && (bus.in_count > N_C));

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign bus.err = err_q && !rst;
`else
  assign bus.err = 1'b0;
`endif
endmodule

// File: tb/tb_unary_expander.sv
// Directed bench for unary_expander: sweep, back-to-back, stall, saturation, reset abort.
module tb_unary_expander;
  localparam int N  = 5;
  localparam int CW = 3;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

`ifdef UNARY_COUNT_ERR_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  unary_expander_if #(.N(N), .CW(CW)) bus ();

  unary_expander #(.N(N), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input string tag, input logic b, input logic l);
    chk({tag, " valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, " bit"},   32'(bus.out_bit),   32'(b));
    chk({tag, " last"},  32'(bus.out_last),  32'(l));
  endtask

  // Inputs change at negedge; checks follow 1 time unit later, far from posedge.
  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    logic [9:0] b2b;
    logic [4:0] stall_seq;
    logic [4:0] one_seq;
    b2b       = 10'b0111100011;   // index 0 is the first beat
    stall_seq = 5'b00111;
    one_seq   = 5'b00001;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_count  = '0;
    bus.out_ready = 1'b1;

    // Reset state, observed within the reset cycles
    cyc(); #1;
    cyc(); #1;
    chk("rst out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst in_ready",  32'(bus.in_ready),  32'd0);
    chk("rst out_bit",   32'(bus.out_bit),   32'd0);
    chk("rst out_last",  32'(bus.out_last),  32'd0);
    chk("rst out_therm", 32'(bus.out_therm), 32'd0);
    chk("rst err",       32'(bus.err),       32'd0);
    cyc(); rst = 1'b0; #1;
    chk("idle in_ready",  32'(bus.in_ready),  32'd1);
    chk("idle out_valid", 32'(bus.out_valid), 32'd0);

    // Sweep counts 0..N with out_ready held high
    for (int c = 0; c <= N; c++) begin
      cyc(); bus.in_valid = 1'b1; bus.in_count = CW'(c); #1;
      chk($sformatf("sweep%0d accept_ready", c), 32'(bus.in_ready), 32'd1);
      for (int b = 0; b < N; b++) begin
        cyc(); bus.in_valid = 1'b0; #1;
        beat($sformatf("sweep%0d beat%0d", c, b), b < c, b == N - 1);
        if (b == 0)
          chk($sformatf("sweep%0d therm", c), 32'(bus.out_therm), (32'd1 << c) - 32'd1);
        chk($sformatf("sweep%0d beat%0d in_ready", c, b), 32'(bus.in_ready),
            32'(b == N - 1));
      end
      cyc(); #1;
      chk($sformatf("sweep%0d idle", c), 32'(bus.out_valid), 32'd0);
    end
    chk("therm count3", 32'(5'b00111), 32'd7);  // literal sanity for the table entry

    // Back-to-back frames 2 then 4 with in_valid held
    cyc(); bus.in_valid = 1'b1; bus.in_count = 3'd2; #1;
    for (int i = 0; i < 2 * N; i++) begin
      cyc();
      if (i == 0) bus.in_count = 3'd4;
      if (i == N) bus.in_valid = 1'b0;
      #1;
      beat($sformatf("b2b beat%0d", i), b2b[i], (i % N) == N - 1);
    end
    cyc(); #1;
    chk("b2b idle", 32'(bus.out_valid), 32'd0);

    // Count 3 with out_ready stalling two cycles before each accepted beat
    cyc(); bus.in_valid = 1'b1; bus.in_count = 3'd3; bus.out_ready = 1'b1; #1;
    for (int b = 0; b < N; b++) begin
      for (int s = 0; s < 2; s++) begin
        cyc(); bus.in_count = 3'd5; bus.out_ready = 1'b0; #1;
        beat($sformatf("stall beat%0d hold%0d", b, s), stall_seq[b], b == N - 1);
        chk($sformatf("stall beat%0d hold%0d therm", b, s), 32'(bus.out_therm), 32'h07);
        chk($sformatf("stall beat%0d hold%0d in_ready", b, s), 32'(bus.in_ready), 32'd0);
      end
      cyc(); bus.out_ready = 1'b1;
      if (b == N - 1) bus.in_valid = 1'b0;
      #1;
      beat($sformatf("stall beat%0d go", b), stall_seq[b], b == N - 1);
      chk($sformatf("stall beat%0d go in_ready", b), 32'(bus.in_ready), 32'(b == N - 1));
    end
    cyc(); #1;
    chk("stall idle", 32'(bus.out_valid), 32'd0);

    // Illegal count 7 saturates to N
    cyc(); bus.in_valid = 1'b1; bus.in_count = 3'd7; #1;
    chk("sat err before", 32'(bus.err), 32'd0);
    for (int b = 0; b < N; b++) begin
      cyc(); bus.in_valid = 1'b0; #1;
      beat($sformatf("sat beat%0d", b), 1'b1, b == N - 1);
      chk($sformatf("sat beat%0d err", b), 32'(bus.err), 32'(ERR_EXP));
    end
    cyc(); #1;
    chk("sat err sticky", 32'(bus.err), 32'(ERR_EXP));

    // Reset after two beats of count 4, with an offered count that must be ignored
    cyc(); bus.in_valid = 1'b1; bus.in_count = 3'd4; #1;
    for (int b = 0; b < 2; b++) begin
      cyc(); bus.in_valid = 1'b0; #1;
      beat($sformatf("abort beat%0d", b), 1'b1, 1'b0);
    end
    cyc(); rst = 1'b1; bus.in_valid = 1'b1; bus.in_count = 3'd3; #1;
    chk("abort rst out_valid", 32'(bus.out_valid), 32'd0);
    chk("abort rst in_ready",  32'(bus.in_ready),  32'd0);
    cyc(); rst = 1'b0; bus.in_count = 3'd1; #1;
    chk("abort post out_valid", 32'(bus.out_valid), 32'd0);
    chk("abort post in_ready",  32'(bus.in_ready),  32'd1);
    chk("abort post err",       32'(bus.err),       32'd0);
    for (int b = 0; b < N; b++) begin
      cyc(); bus.in_valid = 1'b0; #1;
      beat($sformatf("after beat%0d", b), one_seq[b], b == N - 1);
    end
    cyc(); #1;
    chk("after idle", 32'(bus.out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/unary_expander.md
UNARY_EXPANDER -- requirements
Module: unary_expander

Interface
REQ-001 SHALL have parameter: N, 5, frame length in bits; max count accepted.
REQ-002 SHALL have parameter: CW, 3, count width; N SHALL be at most 2^CW-1.
REQ-003 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port: rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port: in_valid  input  1  count word available.
REQ-006 SHALL have port: in_count  input  CW  population count to expand (0..N legal).
REQ-007 SHALL have port: in_ready  output  1  block can accept a count this cycle.
REQ-008 SHALL have port: out_valid  output  1  out_bit/out_last/out_therm valid.
REQ-009 SHALL have port: out_ready  input  1  downstream accepts the current bit.
REQ-010 SHALL have port: out_bit  output  1  current serial unary bit.
REQ-011 SHALL have port: out_last  output  1  current bit is bit N-1 of the frame.
REQ-012 SHALL have port: out_therm  output  N  parallel thermometer code of the frame in progress, with ones in LSBs.
REQ-013 SHALL have port: err  output  1  sticky illegal-count flag.

Function
REQ-014 SHALL implement FSM states IDLE and SHIFT.
REQ-015 Input handshake SHALL occur when in_valid && in_ready.
REQ-016 in_ready SHALL be 1 in IDLE, and 1 in SHIFT only when out_valid && out_ready && out_last; it SHALL be 0 otherwise.
REQ-017 On accept in IDLE: latch count, idx<=0, and go to SHIFT next cycle.
REQ-018 Latency from accept to first out_valid SHALL be 1 cycle.
REQ-019 Latched count above N SHALL saturate to N.
REQ-020 In SHIFT: out_valid=1; out_bit=(idx<count); out_last=(idx==N-1); out_therm bit k=(k<count).
REQ-021 A frame SHALL emit exactly N bits, ones first, LSB-first; count c yields c ones then N-c zeros.
REQ-022 Output beat handshake SHALL occur when out_valid && out_ready; idx SHALL increment only on that handshake.
REQ-023 With out_ready=0, out_bit, out_last, out_therm and idx SHALL hold stable.
REQ-024 Last beat accepted with no new input accepted: go to IDLE, out_valid=0 next cycle.
REQ-025 Last beat accepted with a simultaneous input accept: reload count, idx<=0, stay in SHIFT, with zero bubble between frames.
REQ-026 Count 0 SHALL still emit a full frame of N zeros; count N SHALL emit N ones.
REQ-027 In IDLE: out_valid=0, out_bit=0, out_last=0, out_therm=0.

Reset
REQ-028 rst SHALL force IDLE, idx=0, count=0, err=0, out_valid=0, out_bit=0, out_last=0, out_therm=0, in_ready=0 during the reset cycle.
REQ-029 rst asserted mid-frame SHALL abort the frame without emitting further bits; in_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-030 rst SHALL dominate any simultaneous handshake.

Configuration
REQ-031 Macro UNARY_COUNT_ERR_EN SHALL control illegal-count detection.
REQ-032 With UNARY_COUNT_ERR_EN defined, accepting in_count>N SHALL set err on the next cycle; err SHALL stay set until rst.
REQ-033 Without UNARY_COUNT_ERR_EN, err SHALL be constant 0 and no detection logic SHALL exist.
REQ-034 Saturation per REQ-019 SHALL apply in both builds.

Verification
REQ-035 Sweep in_count 0..5 with out_ready=1 -> each frame has count ones then zeros; out_last is set on the 5th beat; out_therm for 3 = 5'b00111.
REQ-036 Back-to-back counts 2, then 4, with in_valid held -> 10 contiguous valid beats 1,1,0,0,0,1,1,1,1,0 with no gap.
REQ-037 Count 3, out_ready toggling 1,0,0,1,... -> idx frozen while stalled; sequence 1,1,1,0,0 intact; in_ready=0 until the last beat handshake.
REQ-038 in_count=7 -> frame of five ones; err=1 next cycle and stays 1 with UNARY_COUNT_ERR_EN defined; err=0 without it.
REQ-039 rst pulsed after 2 beats of count 4 -> out_valid=0 the next cycle; in_ready=1 after release; a new count 1 emits 1,0,0,0,0.
